prod_accum: RTL
===============

// Module: prod_accum
// PURPOSE
//  Downstream consumer of the signed combinational multiplier's product stream.
//  Accumulates COUNT consecutive signed products into an ACC_W-bit sum and
//  presents each completed sum with a valid/ready handshake (dot-product/MAC tail).
//  Sits between the multiplier output register and the result sink (AXI/BRAM writer).
// PARAMETERS
//  IN_W   8   width of signed input product (multiplier out0 width)
//  ACC_W  16  width of signed accumulator and out_sum; ACC_W >= IN_W
//  COUNT  4   products per completed sum; COUNT >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_prod    in   IN_W   signed product from multiplier
//  in_valid   in   1      in_prod valid this cycle
//  in_ready   out  1      block accepts in_prod this cycle
//  out_sum    out  ACC_W  signed accumulated sum of COUNT products
//  out_ovf    out  1      signed overflow occurred in this group (sticky per group)
//  out_valid  out  1      out_sum/out_ovf valid
//  out_ready  in   1      sink accepts out_sum this cycle
// BEHAVIOUR
//  - Reset: acc=0, cnt=0, ovf_acc=0, out_sum=0, out_ovf=0, out_valid=0.
//    Reset mid-group discards the partial sum and any pending output.
//  - in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
//  - On accept: nxt = acc + sign_extend(in_prod) to ACC_W+1 bits; step overflow when
//    the top two bits of nxt differ. ovf_acc |= step overflow.
//  - cnt counts accepted products 0..COUNT-1; width max(1,$clog2(COUNT)).
//  - Accept with cnt < COUNT-1: acc <= nxt(trunc/sat), cnt++.
//  - Accept with cnt == COUNT-1: out_sum <= nxt(trunc/sat), out_ovf <= ovf_acc|step,
//    out_valid <= 1, acc <= 0, cnt <= 0, ovf_acc <= 0. Latency: out_valid rises
//    the cycle after the COUNT-th accept.
//  - out_valid && out_ready with no new completion: out_valid <= 0 next cycle.
//  - out_valid && out_ready with simultaneous completion: out_valid stays 1 and
//    out_sum/out_ovf update to the new group (full throughput, no bubble).
//  - out_valid && !out_ready: out_sum/out_ovf held stable, in_ready=0, no accepts.
//  - COUNT==1: every accepted product produces one output; acc stays 0.
//  - in_valid with in_ready=0: product ignored; upstream holds it.
// CONFIGURATION
//  SATURATE_EN defined: each step clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on
//   overflow; the clamped value is carried forward into the next step.
//  SATURATE_EN undefined: two's-complement wrap (truncate nxt to ACC_W bits).
//  out_ovf reports overflow identically in both builds.
// TESTING
//  1 Defaults, out_ready=1, products 6,-28,49,-8 back-to-back -> one cycle later
//    out_sum=19, out_ovf=0, out_valid=1 for 1 cycle.
//  2 Back-pressure: out_ready=0 after group 1 -> out_sum held at 19, in_ready=0;
//    next group 1,2,3,4 stalls; raise out_ready -> 19 accepted, then out_sum=10.
//  3 ACC_W=9, products 127,127,127,-128: no SATURATE_EN -> out_sum=253, out_ovf=1;
//    SATURATE_EN -> out_sum=127, out_ovf=1.
//  4 Streaming: out_ready=1, 8 products 1..8 contiguous -> sums 10 then 26,
//    in_ready never deasserts, no idle cycle between groups.
//  5 Reset after 2 accepted products (5,5) -> out_valid=0; then 1,1,1,1 -> out_sum=4.
//  6 COUNT=1: products -64,49 -> out_sum=-64 then 49 on consecutive cycles.

Source files
------------

// File: rtl/prod_accum.sv
//==============================================================================
// prod_accum
//------------------------------------------------------------------------------
// Accumulates COUNT consecutive signed products from the multiplier output
// register into an ACC_W-bit signed sum. Each completed sum is presented to the
// result sink through a valid/ready handshake. A new group can complete in the
// same cycle the previous sum is consumed, so the block streams without bubbles.
//
// Parameters
//   IN_W   width of the signed input product
//   ACC_W  width of the signed accumulator and out_sum (ACC_W >= IN_W)
//   COUNT  products per completed sum (COUNT >= 1)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_prod    in   signed product from the multiplier
//   in_valid   in   in_prod is valid this cycle
//   in_ready   out  block accepts in_prod this cycle
//   out_sum    out  signed sum of COUNT products
//   out_ovf    out  signed overflow occurred somewhere in this group
//   out_valid  out  out_sum/out_ovf are valid
//   out_ready  in   sink accepts out_sum this cycle
//
// Build option
//   SATURATE_EN  defined: each accumulation step clamps to the ACC_W signed
//                range on overflow, and the clamped value feeds the next step.
//                undefined: two's-complement wrap.
//   out_ovf reports overflow the same way in both builds.
//==============================================================================
`timescale 1ns/1ps

module prod_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  in_prod,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int               CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_acc;
    logic signed [ACC_W-1:0] r_out_sum;
    logic                    r_out_ovf;
    logic                    r_out_valid;

    logic                    w_accept;
    logic                    w_last;
    logic [ACC_W:0]          w_prod_ext;
    logic [ACC_W:0]          w_nxt;
    logic                    w_step_ovf;
    logic [ACC_W-1:0]        w_res;

    // The output register can take a new sum when it is empty or being drained
    // this very cycle, which is what gives back-to-back groups full throughput.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_LAST);

    // One guard bit above the accumulator: the step overflowed exactly when the
    // guard bit disagrees with the accumulator's sign bit.
    assign w_prod_ext = {{(ACC_W + 1 - IN_W){in_prod[IN_W-1]}}, in_prod};
    assign w_nxt      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_step_ovf = w_nxt[ACC_W] ^ w_nxt[ACC_W-1];

    // NOTE: every signal driven from always_comb gets a default assignment at
    // the top, so no path through the block can leave it holding a value and
    // infer a latch.
    always_comb begin
        w_res = w_nxt[ACC_W-1:0];
`ifdef SATURATE_EN
        // The guard bit holds the true sign of the overflowed result, so it
        // selects which rail to clamp to.
        if (w_step_ovf) begin
            w_res = w_nxt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    // NOTE: state registers are updated with non-blocking assignments only, so
    // every read in this block sees the value from before the clock edge and
    // ordering of statements cannot change behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // Drain first; a completion in the same cycle overrides it below.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_last) begin
                    r_out_sum   <= w_res;
                    r_out_ovf   <= r_ovf_acc | w_step_ovf;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf_acc   <= 1'b0;
                end else begin
                    r_acc       <= w_res;
                    r_cnt       <= r_cnt + 1'b1;
                    r_ovf_acc   <= r_ovf_acc | w_step_ovf;
                end
            end
        end
    end

    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_valid = r_out_valid;

endmodule
